// File: rtl/bus_arbiter_rr_pkg.sv
// bus_arb_pkg: shared state encoding, owner indices, grant levels and timer width helper for bus_arbiter_rr.
`ifndef BUS_ARB_PKG_DEFS
`define BUS_ARB_PKG_DEFS
`define EN 1'b1
`define DIS_EN 1'b0
`endif

package bus_arb_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_M0, ST_M1} arb_state_t;
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;
    function automatic int hold_w(input int max_hold);
        return (max_hold < 2) ? 1 : $clog2(max_hold);
    endfunction
endpackage

// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: request/grant bundle between the two masters and the arbiter.
interface bus_arbiter_rr_if;
    logic req_m0;
    logic req_m1;
    logic grant_m0;
    logic grant_m1;
    logic owner_o;
    logic busy_o;
    logic preempt_o;
    modport slave (input req_m0, req_m1, output grant_m0, grant_m1, owner_o, busy_o, preempt_o);
    modport master (output req_m0, req_m1, input grant_m0, grant_m1, owner_o, busy_o, preempt_o);
endinterface

// File: rtl/bus_arbiter_rr_hold_timer.sv
// arb_hold_timer: counts contended hold cycles; expire flags the last allowed cycle (ARB_TIMEOUT_EN builds only).
`ifdef ARB_TIMEOUT_EN
module arb_hold_timer
    import bus_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);
    localparam int W = hold_w(MAX_HOLD);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clr ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign expire = (cnt_q == W'(MAX_HOLD - 1));
endmodule
`endif

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: two-master round-robin arbiter with registered exclusive grants.
// Defining ARB_TIMEOUT_EN adds hold-timeout preemption after MAX_HOLD contended cycles.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int   MAX_HOLD  = 16,
    parameter logic INIT_LAST = 1'b1
) (
    input logic clk,
    input logic rst,
    bus_arbiter_rr_if.slave bus
);
    arb_state_t state_q, state_d;
    logic last_q, last_d;
    logic grant_m0_q, grant_m0_d;
    logic grant_m1_q, grant_m1_d;
    logic busy_q, busy_d;
    logic preempt_q, preempt_d;
    logic timeout;

    if (MAX_HOLD < 2) begin : g_hold_chk
        $error("bus_arbiter_rr: MAX_HOLD must be >= 2");
    end

`ifdef ARB_TIMEOUT_EN
    logic hold_inc, hold_clr, expire;
    // only contended hold time counts; any state change restarts the window
    assign hold_inc = (state_q != ST_IDLE) && bus.req_m0 && bus.req_m1;
    assign hold_clr = (state_d != state_q) || !hold_inc;
    assign timeout  = hold_inc && expire;
    arb_hold_timer #(.MAX_HOLD(MAX_HOLD)) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (hold_clr),
        .inc    (hold_inc),
        .expire (expire)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = (bus.req_m0 && bus.req_m1) ? ((last_q == M0) ? ST_M1 : ST_M0) :
                               bus.req_m0 ? ST_M0 : bus.req_m1 ? ST_M1 : ST_IDLE;
            ST_M0:   state_d = bus.req_m0 ? (timeout ? ST_M1 : ST_M0) : bus.req_m1 ? ST_M1 : ST_IDLE;
            ST_M1:   state_d = bus.req_m1 ? (timeout ? ST_M0 : ST_M1) : bus.req_m0 ? ST_M0 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // outputs are decoded from the next state so the grant flops track the state flop exactly
    always_comb begin
        grant_m0_d = (state_d == ST_M0) ? `EN : `DIS_EN;
        grant_m1_d = (state_d == ST_M1) ? `EN : `DIS_EN;
        busy_d     = (state_d != ST_IDLE);
        last_d     = (state_d == ST_M0) ? M0 : (state_d == ST_M1) ? M1 : last_q;
        preempt_d  = timeout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_m0_q <= `DIS_EN;
            grant_m1_q <= `DIS_EN;
            busy_q     <= 1'b0;
            preempt_q  <= 1'b0;
            last_q     <= INIT_LAST;
        end else begin
            grant_m0_q <= grant_m0_d;
            grant_m1_q <= grant_m1_d;
            busy_q     <= busy_d;
            preempt_q  <= preempt_d;
            last_q     <= last_d;
        end
    end

    assign bus.grant_m0  = grant_m0_q;
    assign bus.grant_m1  = grant_m1_q;
    assign bus.owner_o   = last_q;
    assign bus.busy_o    = busy_q;
    assign bus.preempt_o = preempt_q;
endmodule
